// File: rtl/muxb_if.sv
// Port bundle for the registered 2:1 mux: select/data in, registered result out.
interface muxb_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic             s;
    logic [WIDTH-1:0] y;
    logic             y_valid;

    modport master (output d0, d1, s, input  y, y_valid);
    modport slave  (input  d0, d1, s, output y, y_valid);
endinterface

// File: rtl/muxb.sv
// Registered 2:1 mux: captures d1 when s is 1, otherwise d0, on every clock edge.
// y_valid marks that y holds a captured sample rather than the reset value.
module muxb #(
    parameter int WIDTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    muxb_if.slave  bus
);
    logic [WIDTH-1:0] y_q;
    logic             vld_q;

    // An unknown select must fall through to d0, so test s explicitly rather than
    // using a ternary that would merge d0/d1 in simulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q   <= '0;
            vld_q <= 1'b0;
        end else begin
            if (bus.s == 1'b1) y_q <= bus.d1;
            else               y_q <= bus.d0;
            vld_q <= 1'b1;
        end
    end

    assign bus.y       = y_q;
    assign bus.y_valid = vld_q;
endmodule

// File: tb/tb_muxb.sv
// Scoreboard bench for muxb: stimulus queues expected results, a monitor checks them.
module tb_muxb;
    localparam int W = 4;

    typedef struct {
        logic [W-1:0] y;
        logic         v;
        string        name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t q[$];
    int   n_run  = 0;
    int   n_fail = 0;
    bit   done   = 1'b0;

    muxb_if #(.WIDTH(W)) bus ();
    muxb #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] got_y, input logic got_v,
                         input logic [W-1:0] exp_y, input logic exp_v);
        n_run++;
        if (got_y !== exp_y || got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got y=%b v=%b, expected y=%b v=%b", name, got_y, got_v, exp_y, exp_v);
        end
    endtask

    // Drive one edge worth of inputs and queue the result expected after that edge.
    task automatic step(input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sel, input logic [W-1:0] ey, input logic ev,
                        input string name);
        exp_t e;
        rst = r; bus.d0 = a; bus.d1 = b; bus.s = sel;
        e.y = ey; e.v = ev; e.name = name;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: each edge produces one output, checked 3 time units after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                check(e.name, bus.y, bus.y_valid, e.y, e.v);
            end
        end
    end

    initial begin
        rst = 1'b1; bus.d0 = '0; bus.d1 = '0; bus.s = 1'b0;
        #1;

        // Reset held two edges, then release
        step(1, 4'b1111, 4'b1010, 1, 4'b0000, 0, "reset_edge1");
        step(1, 4'b1111, 4'b1010, 1, 4'b0000, 0, "reset_edge2");
        step(0, 4'b1111, 4'b1010, 1, 4'b1010, 1, "reset_release");

        // Basic select
        step(0, 4'b0001, 4'b0010, 0, 4'b0001, 1, "sel_d0");
        step(0, 4'b0001, 4'b0010, 1, 4'b0010, 1, "sel_d1");
        step(0, 4'b0001, 4'b0010, 1, 4'b0010, 1, "sel_hold");

        // Data change with select
        step(0, 4'b1001, 4'b0111, 0, 4'b1001, 1, "data_a");
        step(0, 4'b1010, 4'b1001, 1, 4'b1001, 1, "data_b");
        step(0, 4'b1010, 4'b0111, 0, 4'b1010, 1, "data_c");

        // Latency: mid-cycle select change must not reach y before the edge
        step(0, 4'b1111, 4'b1001, 0, 4'b1111, 1, "lat_pre");
        bus.s = 1'b1;
        #1;
        check("lat_midcycle", bus.y, bus.y_valid, 4'b1111, 1'b1);
        step(0, 4'b1111, 4'b1001, 1, 4'b1001, 1, "lat_post");

        // Mid-stream reset pulse
        step(0, 4'b1111, 4'b1010, 1, 4'b1010, 1, "mid_stream1");
        step(0, 4'b1111, 4'b1010, 1, 4'b1010, 1, "mid_stream2");
        step(1, 4'b1111, 4'b1010, 1, 4'b0000, 0, "mid_reset");
        step(0, 4'b1111, 4'b1010, 1, 4'b1010, 1, "mid_recover");

        // Exhaustive d0/d1/s sweep
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int sel = 0; sel < 2; sel++) begin
                    logic [W-1:0] av, bv;
                    av = W'(a); bv = W'(b);
                    step(0, av, bv, sel[0], (sel == 1) ? bv : av, 1, "exhaustive");
                end

        // Let the monitor drain, bounded
        for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
        #5;
        n_run++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results never checked, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
